fm_cycle_sched: RTL and testbench
=================================

Name: fm_cycle_sched

Overview:
- Time-slot scheduler for the shared frame memory port.
- Grants the memory to four requesters in fixed-length access cycles: input-video write, input-video read, output-video write, output-video read.
- Drives the one-hot cycle flags and the step-advance strobe consumed by the fm_in/fm_out video read/write blocks.
- Also owns the frame_alt / frame_alt_frz double-buffer select, kept in sync with slot boundaries.

Parameters:
- SLOT_LEN, 16, clocks per access cycle; legal range 4..31.
- ADV_LEAD, 2, clocks before slot end at which fm_cycle_stp_adv pulses; legal range 0..SLOT_LEN-2.
- CW, 5, slot counter width; must satisfy 2^CW >= SLOT_LEN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  scheduler enable.
- iv_wr_req  in  1  input-video write request (level).
- iv_rd_req  in  1  input-video read request (level).
- ov_wr_req  in  1  output-video write request (level).
- ov_rd_req  in  1  output-video read request (level).
- vsync  in  1  input vertical sync (synchronous to clk).
- freeze  in  1  holds frame_alt_frz at its current value.
- fm_iv_wr_cycle  out  1  input-video write slot active.
- fm_iv_rd_cycle  out  1  input-video read slot active.
- fm_ov_wr_cycle  out  1  output-video write slot active.
- fm_ov_rd_cycle  out  1  output-video read slot active.
- fm_cycle_stp_adv  out  1  one-clock advance strobe inside each slot.
- frame_alt  out  1  input buffer select.
- frame_alt_frz  out  1  output buffer select, freezable.
- slot_cnt  out  CW  position within the current slot.
- idle  out  1  no slot active.

Behaviour:
- Reset values: all cycle flags 0, fm_cycle_stp_adv 0, frame_alt 0, frame_alt_frz 0, slot_cnt 0, idle 1. The round-robin pointer resets to "last granted = OV_RD", so IV_WR has first priority. rst mid-slot aborts the slot at that edge.
- States:
  - IDLE: no flags asserted.
  - ACTIVE: exactly one flag asserted.
- IDLE -> ACTIVE: taken when en=1 and any request is 1.
  - Grant goes to the first requester after the last granted, in order IV_WR(0), IV_RD(1), OV_WR(2), OV_RD(3), wrapping.
  - The flag rises the clock after the request is sampled; slot_cnt = 0 in the first slot clock.
- ACTIVE: slot_cnt increments every clock, 0..SLOT_LEN-1. The granted flag is held constant for all SLOT_LEN clocks.
- fm_cycle_stp_adv is 1 for exactly the clock where slot_cnt == SLOT_LEN-1-ADV_LEAD; otherwise 0. It is never asserted in IDLE.
- Slot end (slot_cnt == SLOT_LEN-1): requests and en are sampled on that clock.
  - If en=1 and any request is 1: the next slot starts on the following clock with no gap, slot_cnt = 0, and the grant is round-robin from the just-finished requester.
  - Otherwise go to IDLE.
- Requests are level-sensitive. Deasserting a request mid-slot does not shorten the slot; a request is considered only at arbitration points.
- en=0 mid-slot: the current slot completes fully, then the block goes IDLE.
- idle = 1 exactly when no cycle flag is asserted. slot_cnt holds 0 in IDLE.
- vsync:
  - Rising edge detect uses a registered vsync; the edge sets a pending flag.
  - The pending toggle is applied at the next boundary: the slot-end clock in ACTIVE, or the next clock in IDLE.
  - On apply: frame_alt inverts; frame_alt_frz takes the new frame_alt value if freeze=0 at that clock, else holds.
  - A second vsync edge while a toggle is already pending is absorbed (one toggle only).
- Invariant: frame_alt and frame_alt_frz never change in the middle of a slot.
- Invariant: at most one cycle flag is high on any clock.

Test Plan:
- Reset then all four requests held high, SLOT_LEN=16, ADV_LEAD=2 -> flags rotate IV_WR, IV_RD, OV_WR, OV_RD with 16-clock slots and no gaps; stp_adv pulses at slot_cnt=13 of each slot.
- Only ov_rd_req high, others 0 -> back-to-back OV_RD slots; idle stays 0. Drop the request at slot_cnt=5 -> that slot still runs to slot_cnt=15, then idle=1 on the next clock.
- iv_wr_req and ov_wr_req high with pointer at IV_WR -> next grant is OV_WR, then IV_WR; IV_RD and OV_RD are never granted.
- vsync rises at slot_cnt=3 -> frame_alt toggles only after slot_cnt=15; two vsync edges within one slot -> a single toggle. With freeze=1, frame_alt toggles and frame_alt_frz stays constant.
- en dropped at slot_cnt=7 with all requests high -> slot completes, idle=1 afterwards. en raised again -> the next grant follows the round-robin pointer.
- rst asserted at slot_cnt=9 of an IV_RD slot -> all flags 0 and slot_cnt=0 on the next clock. After rst release with all requests high, the first grant is IV_WR.

Source files
------------

// File: rtl/fm_cycle_sched.sv
// Time-slot scheduler for the shared frame memory port: round-robin grant of
// fixed-length access slots to four video requesters, plus double-buffer select.
module fm_cycle_sched #(
  parameter int SLOT_LEN = 16,
  parameter int ADV_LEAD = 2,
  parameter int CW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          iv_wr_req,
  input  logic          iv_rd_req,
  input  logic          ov_wr_req,
  input  logic          ov_rd_req,
  input  logic          vsync,
  input  logic          freeze,
  output logic          fm_iv_wr_cycle,
  output logic          fm_iv_rd_cycle,
  output logic          fm_ov_wr_cycle,
  output logic          fm_ov_rd_cycle,
  output logic          fm_cycle_stp_adv,
  output logic          frame_alt,
  output logic          frame_alt_frz,
  output logic [CW-1:0] slot_cnt,
  output logic          idle
);

  localparam logic [CW-1:0] SLOT_END = CW'(SLOT_LEN - 1);
  localparam logic [CW-1:0] ADV_POS  = CW'(SLOT_LEN - 1 - ADV_LEAD);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vsync_q, vsync_d;
  logic          pend_q, pend_d;
  logic          alt_q, alt_d;
  logic          frz_q, frz_d;

  logic [3:0]    req;
  logic          any_req;
  logic [1:0]    next_gnt;
  logic [1:0]    idx;
  logic          found;
  logic          slot_end;
  logic          boundary;
  logic          apply;

  assign req      = {ov_rd_req, ov_wr_req, iv_rd_req, iv_wr_req};
  assign any_req  = |req;
  assign slot_end = (state_q == S_ACTIVE) && (cnt_q == SLOT_END);
  assign boundary = (state_q == S_IDLE) || slot_end;

  // gnt_q doubles as the round-robin pointer: search starts after it.
  always_comb begin
    next_gnt = gnt_q;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = gnt_q + 2'(k);
      if (!found && req[idx]) begin
        next_gnt = idx;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en && any_req) begin
          state_d = S_ACTIVE;
          gnt_d   = next_gnt;
        end
      end
      S_ACTIVE: begin
        if (slot_end) begin
          cnt_d = '0;
          if (en && any_req) begin
            gnt_d = next_gnt;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A pending buffer toggle lands only on a slot boundary; extra edges are absorbed.
  always_comb begin
    vsync_d = vsync;
    apply   = pend_q && boundary;
    pend_d  = apply ? 1'b0 : (pend_q | (vsync & ~vsync_q));
    alt_d   = alt_q ^ apply;
    frz_d   = (apply && !freeze) ? ~alt_q : frz_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'd3;
      cnt_q   <= '0;
      vsync_q <= 1'b0;
      pend_q  <= 1'b0;
      alt_q   <= 1'b0;
      frz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      vsync_q <= vsync_d;
      pend_q  <= pend_d;
      alt_q   <= alt_d;
      frz_q   <= frz_d;
    end
  end

  assign fm_iv_wr_cycle   = (state_q == S_ACTIVE) && (gnt_q == 2'd0);
  assign fm_iv_rd_cycle   = (state_q == S_ACTIVE) && (gnt_q == 2'd1);
  assign fm_ov_wr_cycle   = (state_q == S_ACTIVE) && (gnt_q == 2'd2);
  assign fm_ov_rd_cycle   = (state_q == S_ACTIVE) && (gnt_q == 2'd3);
  assign fm_cycle_stp_adv = (state_q == S_ACTIVE) && (cnt_q == ADV_POS);
  assign frame_alt        = alt_q;
  assign frame_alt_frz    = frz_q;
  assign slot_cnt         = cnt_q;
  assign idle             = (state_q == S_IDLE);

endmodule

// File: tb/tb_fm_cycle_sched.sv
// Randomized and directed bench for fm_cycle_sched against a slot-level
// behavioural model of the scheduler.
module tb_fm_cycle_sched;

  localparam int L  = 16;
  localparam int A  = 2;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [3:0]    req = 4'b0;
  logic          vsync = 1'b0;
  logic          freeze = 1'b0;
  logic          fm_iv_wr_cycle, fm_iv_rd_cycle, fm_ov_wr_cycle, fm_ov_rd_cycle;
  logic          fm_cycle_stp_adv, frame_alt, frame_alt_frz, idle;
  logic [CW-1:0] slot_cnt;

  int checks = 0;
  int errors = 0;

  // model: owner of the current slot (also the round-robin pointer) and position
  bit m_act;
  int m_pos;
  int m_own;
  bit m_alt, m_frz, m_pend, m_vprev;

  fm_cycle_sched #(.SLOT_LEN(L), .ADV_LEAD(A), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .iv_wr_req(req[0]), .iv_rd_req(req[1]), .ov_wr_req(req[2]), .ov_rd_req(req[3]),
    .vsync(vsync), .freeze(freeze),
    .fm_iv_wr_cycle(fm_iv_wr_cycle), .fm_iv_rd_cycle(fm_iv_rd_cycle),
    .fm_ov_wr_cycle(fm_ov_wr_cycle), .fm_ov_rd_cycle(fm_ov_rd_cycle),
    .fm_cycle_stp_adv(fm_cycle_stp_adv), .frame_alt(frame_alt),
    .frame_alt_frz(frame_alt_frz), .slot_cnt(slot_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] obs();
    return {fm_ov_rd_cycle, fm_ov_wr_cycle, fm_iv_rd_cycle, fm_iv_wr_cycle,
            fm_cycle_stp_adv, frame_alt, frame_alt_frz, slot_cnt, idle};
  endfunction

  function automatic logic [12:0] expv();
    logic [3:0] fl;
    fl = m_act ? (4'b1 << m_own) : 4'b0;
    return {fl, 1'(m_act && m_pos == L - 1 - A), m_alt, m_frz, CW'(m_pos), ~m_act};
  endfunction

  // Applies one clock of the scheduling rules to the model using the sampled inputs.
  task automatic model_step();
    bit at_bound, rise;
    if (rst) begin
      m_act = 0; m_pos = 0; m_own = 3;
      m_alt = 0; m_frz = 0; m_pend = 0; m_vprev = 0;
      return;
    end
    at_bound = !m_act || (m_pos == L - 1);
    rise     = vsync && !m_vprev;
    m_vprev  = vsync;
    if (m_pend && at_bound) begin
      m_alt  = !m_alt;
      if (!freeze) m_frz = m_alt;
      m_pend = 0;
    end else if (rise) begin
      m_pend = 1;
    end
    if (at_bound) begin
      m_pos = 0;
      m_act = 0;
      if (en && req != 4'b0) begin
        for (int k = 1; k <= 4; k++) begin
          if (req[(m_own + k) % 4]) begin
            m_own = (m_own + k) % 4;
            m_act = 1;
            break;
          end
        end
      end
    end else begin
      m_pos++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; req = 4'b0; vsync = 0; freeze = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; req = 4'hF;
    tick(); tick();
    checks++;
    if (obs() !== 13'b0000_0_0_0_00000_1) begin
      errors++; $display("FAIL reset_state got %b exp %b", obs(), 13'b0000_0_0_0_00000_1);
    end
    rst = 0;
  endtask

  task automatic test_rotation();
    int stp_seen = 0;
    en = 1; req = 4'hF;
    for (int i = 0; i < 4 * L + 2; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL rotation cyc %0d got %b exp %b", i, obs(), expv());
      end
      if (fm_cycle_stp_adv) stp_seen++;
    end
    checks++;
    if (stp_seen != 4) begin
      errors++; $display("FAIL rotation_stp_count got %0d exp 4", stp_seen);
    end
  endtask

  task automatic test_single_drop();
    int slots = 0;
    do_reset();
    en = 1; req = 4'b1000;
    for (int i = 0; i < 200 && !(slots == 2 && m_pos == 5); i++) begin
      tick();
      if (m_act && m_pos == 0) slots++;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL single cyc %0d got %b exp %b", i, obs(), expv());
      end
    end
    checks++;
    if (!(slots == 2 && m_pos == 5)) begin
      errors++; $display("FAIL single_timeout got slots %0d exp 2", slots);
    end
    req = 4'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL single_drop cyc %0d got %b exp %b", i, obs(), expv());
      end
    end
    checks++;
    if (idle !== 1'b1 || fm_ov_rd_cycle !== 1'b0) begin
      errors++; $display("FAIL single_idle got idle %b ovrd %b exp 1 0", idle, fm_ov_rd_cycle);
    end
  endtask

  task automatic test_two_req();
    do_reset();
    en = 1; req = 4'b0101;
    for (int i = 0; i < 4 * L + 1; i++) begin
      tick();
      checks++;
      if (obs() !== expv() || fm_iv_rd_cycle || fm_ov_rd_cycle) begin
        errors++; $display("FAIL two_req cyc %0d got %b exp %b", i, obs(), expv());
      end
    end
  endtask

  task automatic test_vsync();
    logic prev_alt, prev_frz;
    do_reset();
    en = 1; req = 4'hF;
    prev_alt = 0; prev_frz = 0;
    for (int i = 0; i < 5 * L; i++) begin
      if (i == L + 4 || i == L + 8 || i == 3 * L + 4) vsync = 1;
      if (i == L + 6 || i == L + 10 || i == 3 * L + 6) vsync = 0;
      freeze = (i >= 2 * L + 4);
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL vsync cyc %0d got %b exp %b", i, obs(), expv());
      end
      checks++;
      if (!idle && slot_cnt != 0 && (frame_alt !== prev_alt || frame_alt_frz !== prev_frz)) begin
        errors++; $display("FAIL vsync_midslot cyc %0d got alt %b frz %b exp %b %b",
                           i, frame_alt, frame_alt_frz, prev_alt, prev_frz);
      end
      prev_alt = frame_alt; prev_frz = frame_alt_frz;
    end
    checks++;
    if (frame_alt !== 1'b0 || frame_alt_frz !== 1'b1) begin
      errors++; $display("FAIL vsync_final got alt %b frz %b exp 0 1", frame_alt, frame_alt_frz);
    end
    freeze = 0;
  endtask

  task automatic test_en_drop();
    do_reset();
    en = 1; req = 4'hF;
    for (int i = 0; i < 200 && !(m_act && m_own == 1 && m_pos == 7); i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL en_wait cyc %0d got %b exp %b", i, obs(), expv());
      end
    end
    en = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL en_drop cyc %0d got %b exp %b", i, obs(), expv());
      end
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++; $display("FAIL en_idle got %b exp 1", idle);
    end
    en = 1;
    tick();
    checks++;
    if (fm_ov_wr_cycle !== 1'b1 || obs() !== expv()) begin
      errors++; $display("FAIL en_resume got %b exp %b", obs(), expv());
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    en = 1; req = 4'hF;
    for (int i = 0; i < 200 && !(m_act && m_own == 1 && m_pos == 9); i++) tick();
    rst = 1;
    tick();
    checks++;
    if (obs() !== 13'b0000_0_0_0_00000_1) begin
      errors++; $display("FAIL rst_mid got %b exp %b", obs(), 13'b0000_0_0_0_00000_1);
    end
    rst = 0;
    tick();
    checks++;
    if (fm_iv_wr_cycle !== 1'b1 || slot_cnt !== 5'd0) begin
      errors++; $display("FAIL rst_first_grant got ivwr %b cnt %0d exp 1 0", fm_iv_wr_cycle, slot_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      en     = ($urandom_range(0, 15) != 0);
      vsync  = ($urandom_range(0, 9) == 0) ? ~vsync : vsync;
      freeze = ($urandom_range(0, 3) == 0);
      rst    = ($urandom_range(0, 499) == 0);
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random cyc %0d got %b exp %b", i, obs(), expv());
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single_drop();
    test_two_req();
    test_vsync();
    test_en_drop();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
